// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops one word per frame from a FIFO read port and
// serialises it as start, data (LSB first), optional parity and stop bits.
module fifo_uart_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  fifo_rd_val,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  fifo_rd_en,
   output logic                  tx,
   output logic                  busy,
   output logic                  frame_done
);
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
   localparam logic              ODD_BIT   = (PARITY_ODD != 0);

   typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;

   state_t                state, state_next;
   logic [BAUD_W-1:0]     baud_cnt, baud_next;
   logic [BIT_W-1:0]      bit_cnt, bit_next;
   logic [DATA_WIDTH-1:0] shift, shift_next;
   logic                  parity, parity_next;
   logic                  tx_next;
   logic                  done_next;
   logic                  bit_end;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         shift      <= '0;
         parity     <= 1'b0;
         tx         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         state      <= state_next;
         baud_cnt   <= baud_next;
         bit_cnt    <= bit_next;
         shift      <= shift_next;
         parity     <= parity_next;
         tx         <= tx_next;
         frame_done <= done_next;
      end
   end

   // tx_next is the line level for the state being entered, so tx itself stays a flop output
   always_comb begin
      state_next  = state;
      baud_next   = '0;
      bit_next    = bit_cnt;
      shift_next  = shift;
      parity_next = parity;
      tx_next     = tx;
      done_next   = 1'b0;
      fifo_rd_en  = 1'b0;
      busy        = (state != IDLE);
      bit_end     = (baud_cnt == BAUD_LAST);

      if (state != IDLE && state != LOAD)
         baud_next = bit_end ? '0 : baud_cnt + 1'b1;

      case (state)
         IDLE: begin
            tx_next    = 1'b1;
            fifo_rd_en = fifo_rd_val && reset_n;
            if (fifo_rd_val)
               state_next = LOAD;
         end
         LOAD: begin
            shift_next  = fifo_rd_data;
            bit_next    = '0;
            parity_next = 1'b0;
            tx_next     = 1'b0;
            state_next  = START;
         end
         START: begin
            if (bit_end) begin
               tx_next    = shift[0];
               state_next = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               parity_next = parity ^ shift[0];
               shift_next  = shift >> 1;
               if (bit_cnt == DATA_LAST) begin
                  bit_next = '0;
                  if (PARITY_EN != 0) begin
                     tx_next    = parity ^ shift[0] ^ ODD_BIT;
                     state_next = PARITY;
                  end else begin
                     tx_next    = 1'b1;
                     state_next = STOP;
                  end
               end else begin
                  bit_next = bit_cnt + 1'b1;
                  tx_next  = shift[1];
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               tx_next    = 1'b1;
               bit_next   = '0;
               state_next = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (bit_cnt == STOP_LAST) begin
                  bit_next   = '0;
                  done_next  = 1'b1;
                  state_next = IDLE;
               end else begin
                  bit_next = bit_cnt + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end
endmodule
